// File: rtl/z3_slave_sequencer.sv
// z3_slave_sequencer: Zorro III slave-cycle sequencer for NUM_REGIONS one-hot target regions.
// FCS_n, DS_n and DOE are synchronised; addr_match, region_sel, FC, READ and region_ack are
// treated as stable or level inputs. The optional bus-error timeout is enabled by defining
// the macro Z3_TIMEOUT_EN.
module z3_slave_sequencer #(
  parameter int unsigned NUM_REGIONS    = 5,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   FCS_n,
  input  logic [3:0]             DS_n,
  input  logic                   DOE,
  input  logic                   READ,
  input  logic [2:0]             FC,
  input  logic                   addr_match,
  input  logic [NUM_REGIONS-1:0] region_sel,
  input  logic [NUM_REGIONS-1:0] region_ack,
  output logic [NUM_REGIONS-1:0] region_req,
  output logic                   cycle_read,
  output logic                   slave,
  output logic                   dtack,
  output logic                   berr,
  output logic                   busy
);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_END, ST_ERROR} state_t;

  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_fcs_sync, r_ds_sync, r_doe_sync;
  logic                   w_fcs_s, w_ds_s, w_doe_s;
  logic                   w_valid, w_onehot, w_ack_hit, w_go_idle;
  logic [NUM_REGIONS-1:0] r_reg, w_reg_nxt, r_req, w_req_nxt;
  logic                   r_slave, w_slave_nxt, r_dtack, w_dtack_nxt;
  logic                   r_read, w_read_nxt, r_lock, w_lock_nxt, r_busy;

`ifdef Z3_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_berr, w_berr_nxt;
`else
  logic w_unused;
  assign w_unused = ^{FC[2], TIMEOUT_CYCLES[0]};
`endif

  assign w_fcs_s   = r_fcs_sync[SYNC_STAGES-1];
  assign w_ds_s    = r_ds_sync[SYNC_STAGES-1];
  assign w_doe_s   = r_doe_sync[SYNC_STAGES-1];
  assign w_valid   = FC[1] ^ FC[0];
  assign w_onehot  = (region_sel != '0) &&
                     ((region_sel & (region_sel - NUM_REGIONS'(1))) == '0);
  assign w_ack_hit = (region_ack & r_reg) != '0;

  // Synchronisers for the asynchronous bus strobes, reset to their inactive levels
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_fcs_sync <= '1;
      r_ds_sync  <= '0;
      r_doe_sync <= '0;
    end else begin
      r_fcs_sync <= {r_fcs_sync[SYNC_STAGES-2:0], FCS_n};
      r_ds_sync  <= {r_ds_sync[SYNC_STAGES-2:0], (DS_n != 4'b1111)};
      r_doe_sync <= {r_doe_sync[SYNC_STAGES-2:0], DOE};
    end
  end

  // State and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_reg   <= '0;
      r_req   <= '0;
      r_slave <= 1'b0;
      r_dtack <= 1'b0;
      r_read  <= 1'b0;
      r_lock  <= 1'b0;
      r_busy  <= 1'b0;
`ifdef Z3_TIMEOUT_EN
      r_cnt   <= '0;
      r_berr  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_reg   <= w_reg_nxt;
      r_req   <= w_req_nxt;
      r_slave <= w_slave_nxt;
      r_dtack <= w_dtack_nxt;
      r_read  <= w_read_nxt;
      r_lock  <= w_lock_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
`ifdef Z3_TIMEOUT_EN
      r_cnt   <= w_cnt_nxt;
      r_berr  <= w_berr_nxt;
`endif
    end
  end

  // Next-state and next-output decode; FCS deassert overrides everything outside IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_reg_nxt   = r_reg;
    w_req_nxt   = r_req;
    w_slave_nxt = r_slave;
    w_dtack_nxt = r_dtack;
    w_read_nxt  = r_read;
    w_lock_nxt  = r_lock;
    w_go_idle   = 1'b0;
`ifdef Z3_TIMEOUT_EN
    w_cnt_nxt   = r_cnt;
    w_berr_nxt  = r_berr;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_fcs_s) begin
          w_lock_nxt = 1'b0;
        end else if (!r_lock) begin
          if (addr_match && w_valid && w_onehot) begin
            w_state_nxt = ST_START;
            w_reg_nxt   = region_sel;
            w_read_nxt  = READ;
            w_slave_nxt = 1'b1;
          end else begin
            w_lock_nxt  = 1'b1;
          end
        end
      end
      ST_START: begin
        if (w_fcs_s) begin
          w_go_idle   = 1'b1;
        end else if (w_ds_s && w_doe_s) begin
          w_state_nxt = ST_DATA;
          w_req_nxt   = r_reg;
`ifdef Z3_TIMEOUT_EN
          w_cnt_nxt   = '0;
`endif
        end
      end
      ST_DATA: begin
        if (w_fcs_s) begin
          w_go_idle   = 1'b1;
        end else if (w_ack_hit) begin
          w_state_nxt = ST_END;
          w_dtack_nxt = 1'b1;
          w_req_nxt   = '0;
        end
`ifdef Z3_TIMEOUT_EN
        else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_state_nxt = ST_ERROR;
          w_req_nxt   = '0;
          w_berr_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
`endif
      end
      ST_END: begin
        if (w_fcs_s) w_go_idle = 1'b1;
      end
`ifdef Z3_TIMEOUT_EN
      ST_ERROR: begin
        if (w_fcs_s) w_go_idle = 1'b1;
      end
`endif
      default: w_go_idle = 1'b1;
    endcase
    if (w_go_idle) begin
      w_state_nxt = ST_IDLE;
      w_reg_nxt   = '0;
      w_req_nxt   = '0;
      w_slave_nxt = 1'b0;
      w_dtack_nxt = 1'b0;
`ifdef Z3_TIMEOUT_EN
      w_berr_nxt  = 1'b0;
`endif
    end
  end

  assign region_req = r_req;
  assign cycle_read = r_read;
  assign slave      = r_slave;
  assign dtack      = r_dtack;
  assign busy       = r_busy;
`ifdef Z3_TIMEOUT_EN
  assign berr       = r_berr;
`else
  assign berr       = 1'b0;
`endif

endmodule

// File: tb/tb_z3_slave_sequencer.sv
// Testbench for z3_slave_sequencer: expectations come from the bus-level latency rules
// (slave SYNC_STAGES+1 edges after FCS low, request one edge later, dtack on the ack edge,
// release SYNC_STAGES+1 edges after FCS high) and a legality predicate on FC/addr/region.
module tb_z3_slave_sequencer;
  localparam int unsigned N  = 5;
  localparam int unsigned S  = 2;
  localparam int unsigned TO = 8;
`ifdef Z3_TIMEOUT_EN
  localparam int unsigned WRONG_CYC = TO - 3;
`else
  localparam int unsigned WRONG_CYC = 20;
`endif

  logic         CLK = 1'b0;
  logic         RESET, FCS_n, DOE, READ, addr_match;
  logic [3:0]   DS_n;
  logic [2:0]   FC;
  logic [N-1:0] region_sel, region_ack, region_req;
  logic         cycle_read, slave, dtack, berr, busy;
  int           n_cmp = 0;
  int           n_err = 0;

  always #20 CLK = ~CLK;

  z3_slave_sequencer #(.NUM_REGIONS(N), .SYNC_STAGES(S), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RESET(RESET), .FCS_n(FCS_n), .DS_n(DS_n), .DOE(DOE), .READ(READ),
    .FC(FC), .addr_match(addr_match), .region_sel(region_sel), .region_ack(region_ack),
    .region_req(region_req), .cycle_read(cycle_read), .slave(slave), .dtack(dtack),
    .berr(berr), .busy(busy)
  );

  logic [N+3:0] obs;
  assign obs = {slave, dtack, busy, berr, region_req};

  function automatic logic [N+3:0] ev(logic s, logic d, logic b, logic e, logic [N-1:0] r);
    return {s, d, b, e, r};
  endfunction

  function automatic bit legal(logic [2:0] fc, logic am, logic [N-1:0] sel);
    return am && (fc[1] ^ fc[0]) && ($countones(sel) == 1);
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_bus;
    FCS_n = 1'b1; DS_n = 4'hF; DOE = 1'b0; region_ack = '0;
  endtask

  function automatic logic [2:0] rand_valid_fc();
    logic [2:0] f;
    f = 3'($urandom_range(0, 7));
    f[0] = ~f[1];
    return f;
  endfunction

  function automatic logic [N-1:0] rand_onehot();
    return N'(1) << $urandom_range(0, N - 1);
  endfunction

  // Drive a cycle start; legal cycles are followed into DATA, illegal ones are watched for quiet
  task automatic open_cycle(input logic [2:0] fc, input logic am, input logic [N-1:0] sel,
                            input logic rd, output bit ok);
    FC = fc; addr_match = am; region_sel = sel; READ = rd;
    FCS_n = 1'b0; DS_n = 4'($urandom_range(0, 14)); DOE = 1'b1; region_ack = '0;
    ok = legal(fc, am, sel);
    if (!ok) begin
      for (int i = 0; i < int'(S) + 12; i++) begin
        region_ack = N'($urandom);
        tick();
        n_cmp++;
        if (obs !== ev(0, 0, 0, 0, '0)) begin
          n_err++;
          $display("FAIL illegal_hold: got %b want %b", obs, ev(0, 0, 0, 0, '0));
        end
      end
      region_ack = '0;
    end else begin
      repeat (S) begin
        tick();
        n_cmp++;
        if (obs !== ev(0, 0, 0, 0, '0)) begin
          n_err++;
          $display("FAIL pre_start: got %b want %b", obs, ev(0, 0, 0, 0, '0));
        end
      end
      tick();
      n_cmp++;
      if ({obs, cycle_read} !== {ev(1, 0, 1, 0, '0), rd}) begin
        n_err++;
        $display("FAIL start: got %b/%b want %b/%b", obs, cycle_read, ev(1, 0, 1, 0, '0), rd);
      end
      tick();
      n_cmp++;
      if (obs !== ev(1, 0, 1, 0, sel)) begin
        n_err++;
        $display("FAIL data_req: got %b want %b", obs, ev(1, 0, 1, 0, sel));
      end
    end
  endtask

  // Hold in DATA with wrong-channel acks, then ack the selected channel and expect dtack
  task automatic ack_cycle(input logic [N-1:0] sel, input int wrong);
    for (int i = 0; i < wrong; i++) begin
      region_ack = N'($urandom) & ~sel;
      tick();
      n_cmp++;
      if (obs !== ev(1, 0, 1, 0, sel)) begin
        n_err++;
        $display("FAIL wrong_ack: got %b want %b", obs, ev(1, 0, 1, 0, sel));
      end
    end
    region_ack = sel | (N'($urandom) & ~sel);
    tick();
    n_cmp++;
    if (obs !== ev(1, 1, 1, 0, '0)) begin
      n_err++;
      $display("FAIL dtack: got %b want %b", obs, ev(1, 1, 1, 0, '0));
    end
    region_ack = '0;
  endtask

  // Release FCS: outputs hold for S edges, then return to idle
  task automatic close_cycle(input logic [N+3:0] hold);
    idle_bus();
    repeat (S) begin
      tick();
      n_cmp++;
      if (obs !== hold) begin
        n_err++;
        $display("FAIL release_hold: got %b want %b", obs, hold);
      end
    end
    tick();
    n_cmp++;
    if (obs !== ev(0, 0, 0, 0, '0)) begin
      n_err++;
      $display("FAIL release: got %b want %b", obs, ev(0, 0, 0, 0, '0));
    end
  endtask

  task automatic test_reset;
    RESET = 1'b1; idle_bus();
    FC = 3'b001; addr_match = 1'b0; region_sel = '0; READ = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({obs, cycle_read} !== {ev(0, 0, 0, 0, '0), 1'b0}) begin
      n_err++;
      $display("FAIL reset: got %b/%b want %b/0", obs, cycle_read, ev(0, 0, 0, 0, '0));
    end
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_normal_read;
    bit ok;
    open_cycle(3'b001, 1'b1, 5'b00100, 1'b1, ok);
    ack_cycle(5'b00100, 0);
    repeat (3) begin
      tick();
      n_cmp++;
      if (obs !== ev(1, 1, 1, 0, '0)) begin
        n_err++;
        $display("FAIL dtack_hold: got %b want %b", obs, ev(1, 1, 1, 0, '0));
      end
    end
    close_cycle(ev(1, 1, 1, 0, '0));
  endtask

  task automatic test_illegal;
    bit ok;
    open_cycle(3'b001, 1'b1, 5'b00110, 1'b0, ok);
    close_cycle(ev(0, 0, 0, 0, '0));
    open_cycle(3'b011, 1'b1, 5'b00100, 1'b0, ok);
    close_cycle(ev(0, 0, 0, 0, '0));
    open_cycle(3'b010, 1'b1, 5'b00000, 1'b0, ok);
    close_cycle(ev(0, 0, 0, 0, '0));
    open_cycle(3'b101, 1'b1, 5'b01000, 1'b0, ok);
    ack_cycle(5'b01000, 2);
    close_cycle(ev(1, 1, 1, 0, '0));
  endtask

  task automatic test_abort;
    bit ok;
    logic [N-1:0] sel;
    sel = rand_onehot();
    open_cycle(rand_valid_fc(), 1'b1, sel, 1'($urandom), ok);
    idle_bus();
    repeat (S) begin
      tick();
      n_cmp++;
      if (obs !== ev(1, 0, 1, 0, sel)) begin
        n_err++;
        $display("FAIL abort_wait: got %b want %b", obs, ev(1, 0, 1, 0, sel));
      end
    end
    region_ack = sel;
    repeat (3) begin
      tick();
      n_cmp++;
      if (obs !== ev(0, 0, 0, 0, '0)) begin
        n_err++;
        $display("FAIL abort: got %b want %b", obs, ev(0, 0, 0, 0, '0));
      end
    end
    region_ack = '0;
  endtask

  task automatic test_wrong_channel;
    bit ok;
    open_cycle(3'b110, 1'b1, 5'b00001, 1'b0, ok);
    for (int i = 0; i < int'(WRONG_CYC); i++) begin
      region_ack = 5'b00010;
      tick();
      n_cmp++;
      if (obs !== ev(1, 0, 1, 0, 5'b00001)) begin
        n_err++;
        $display("FAIL wrong_channel: got %b want %b", obs, ev(1, 0, 1, 0, 5'b00001));
      end
    end
    ack_cycle(5'b00001, 0);
    close_cycle(ev(1, 1, 1, 0, '0));
  endtask

  task automatic test_back_to_back_random;
    bit ok;
    logic [2:0] fc;
    logic am;
    logic [N-1:0] sel;
    for (int k = 0; k < 12; k++) begin
      fc  = ($urandom_range(0, 3) != 0) ? rand_valid_fc() : 3'($urandom_range(0, 7));
      am  = ($urandom_range(0, 5) != 0);
      sel = ($urandom_range(0, 2) != 0) ? rand_onehot() : N'($urandom);
      open_cycle(fc, am, sel, 1'($urandom), ok);
      if (ok) begin
        ack_cycle(sel, $urandom_range(0, 4));
        close_cycle(ev(1, 1, 1, 0, '0));
      end else begin
        close_cycle(ev(0, 0, 0, 0, '0));
      end
    end
  endtask

  task automatic test_reset_in_end;
    bit ok;
    logic [N-1:0] sel;
    sel = rand_onehot();
    open_cycle(rand_valid_fc(), 1'b1, sel, 1'b1, ok);
    ack_cycle(sel, 1);
    RESET = 1'b1;
    tick();
    n_cmp++;
    if ({obs, cycle_read} !== {ev(0, 0, 0, 0, '0), 1'b0}) begin
      n_err++;
      $display("FAIL reset_in_end: got %b/%b want %b/0", obs, cycle_read, ev(0, 0, 0, 0, '0));
    end
    idle_bus();
    tick();
    RESET = 1'b0;
    repeat (S) tick();
    open_cycle(rand_valid_fc(), 1'b1, sel, 1'b0, ok);
    ack_cycle(sel, 0);
    close_cycle(ev(1, 1, 1, 0, '0));
  endtask

`ifdef Z3_TIMEOUT_EN
  task automatic test_timeout;
    bit ok;
    logic [N-1:0] sel;
    sel = rand_onehot();
    open_cycle(rand_valid_fc(), 1'b1, sel, 1'b0, ok);
    repeat (TO - 1) tick();
    n_cmp++;
    if (obs !== ev(1, 0, 1, 0, sel)) begin
      n_err++;
      $display("FAIL pre_timeout: got %b want %b", obs, ev(1, 0, 1, 0, sel));
    end
    tick();
    n_cmp++;
    if (obs !== ev(1, 0, 1, 1, '0)) begin
      n_err++;
      $display("FAIL berr: got %b want %b", obs, ev(1, 0, 1, 1, '0));
    end
    close_cycle(ev(1, 0, 1, 1, '0));
    open_cycle(rand_valid_fc(), 1'b1, sel, 1'b0, ok);
    repeat (TO - 1) tick();
    ack_cycle(sel, 0);
    close_cycle(ev(1, 1, 1, 0, '0));
  endtask
`endif

  initial begin
    test_reset();
    test_normal_read();
    test_illegal();
    test_abort();
    test_wrong_channel();
    test_back_to_back_random();
    test_reset_in_end();
`ifdef Z3_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
